// File: rtl/npu_tile_scheduler.sv
// Tile job scheduler: queues (tile_i, tile_j, op) jobs and issues them one at a
// time to the tile processor with a start pulse, done wait and timeout guard.
module npu_tile_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [2:0]    job_tile_i,
    input  logic [2:0]    job_tile_j,
    input  logic [2:0]    job_op,
    input  logic          abort,
    output logic          tp_start,
    output logic [2:0]    tp_tile_i,
    output logic [2:0]    tp_tile_j,
    output logic [2:0]    tp_op_code,
    input  logic          tp_done,
    output logic          busy,
    output logic [CW-1:0] jobs_pending,
    output logic [15:0]   jobs_completed,
    output logic          irq_done,
    output logic          err_timeout,
    input  logic          err_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [8:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    tile_i_q, tile_j_q, op_q;
    logic [15:0]   completed_q;
    logic          irq_q;
    logic          err_q, err_d;

    logic fifo_empty, fifo_full, expired;
    logic push, pop, complete, timeout_hit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == COUNT_FULL);
    assign expired    = (timer_q == TIMER_LAST);

    // Abort blocks both FIFO ports so a same-cycle push is discarded by the flush.
    assign push = job_valid && !fifo_full && !abort;
    assign pop  = (state_q == IDLE) && !fifo_empty && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = abort ? DRAIN : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (tp_done || expired) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!abort && (tp_done || expired)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Done has priority over expiry, so a completion in the last timer cycle counts.
    always_comb begin
        tp_start    = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        timer_d     = timer_q;
        case (state_q)
            ISSUE: begin
                tp_start = 1'b1;
                timer_d  = '0;
            end
            WAIT: begin
                timer_d     = timer_q + 1'b1;
                complete    = !abort && tp_done;
                timeout_hit = !abort && !tp_done && expired;
            end
            DRAIN: begin
                timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_clear) begin
            err_d = 1'b0;
        end else if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {job_tile_i, job_tile_j, job_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            tile_i_q    <= '0;
            tile_j_q    <= '0;
            op_q        <= '0;
            completed_q <= '0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            irq_q    <= complete;
            if (complete) begin
                completed_q <= completed_q + 16'd1;
            end
            if (pop) begin
                {tile_i_q, tile_j_q, op_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    assign job_ready      = !fifo_full;
    assign jobs_pending   = count_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;
    assign tp_tile_i      = tile_i_q;
    assign tp_tile_j      = tile_j_q;
    assign tp_op_code     = op_q;
    assign jobs_completed = completed_q;
    assign irq_done       = irq_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Directed bench for npu_tile_scheduler with DEPTH=4 and TIMEOUT=16; the bench
// plays the tile processor by driving tp_done by hand.
module tb_npu_tile_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [2:0]    job_tile_i, job_tile_j, job_op;
    logic          abort;
    logic          tp_start;
    logic [2:0]    tp_tile_i, tp_tile_j, tp_op_code;
    logic          tp_done;
    logic          busy;
    logic [CW-1:0] jobs_pending;
    logic [15:0]   jobs_completed;
    logic          irq_done;
    logic          err_timeout;
    logic          err_clear;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_completed = 0;

    npu_tile_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_tile_i(job_tile_i), .job_tile_j(job_tile_j), .job_op(job_op),
        .abort(abort),
        .tp_start(tp_start), .tp_tile_i(tp_tile_i), .tp_tile_j(tp_tile_j),
        .tp_op_code(tp_op_code), .tp_done(tp_done),
        .busy(busy), .jobs_pending(jobs_pending), .jobs_completed(jobs_completed),
        .irq_done(irq_done), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [2:0] ti, input logic [2:0] tj, input logic [2:0] op);
        job_valid  = 1'b1;
        job_tile_i = ti;
        job_tile_j = tj;
        job_op     = op;
        tick();
        job_valid  = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            tick();
            if (tp_start === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (tp_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tp_start: got %b want 0", tp_start); end
        n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_job_ready: got %b want 1", job_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (jobs_pending !== '0) begin n_fail++; $display("[TB] FAIL reset_pending: got %0d want 0", jobs_pending); end
        n_checks++; if (jobs_completed !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_completed: got %0d want 0", jobs_completed); end
        n_checks++; if ({irq_done, err_timeout} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_irq_err: got %b want 00", {irq_done, err_timeout}); end
        n_checks++; if ({tp_tile_i, tp_tile_j, tp_op_code} !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_fields: got %h want 0", {tp_tile_i, tp_tile_j, tp_op_code}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        int extra;
        push_job(3'd1, 3'd2, 3'd3);
        n_checks++; if (jobs_pending !== CW'(1)) begin n_fail++; $display("[TB] FAIL single_pending: got %0d want 1", jobs_pending); end
        n_checks++; if (tp_start !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_start: got %b want 0", tp_start); end
        tick();
        n_checks++; if (tp_start !== 1'b1) begin n_fail++; $display("[TB] FAIL single_start: got %b want 1", tp_start); end
        n_checks++; if ({tp_tile_i, tp_tile_j, tp_op_code} !== {3'd1, 3'd2, 3'd3}) begin n_fail++; $display("[TB] FAIL single_fields: got %0d/%0d/%0d want 1/2/3", tp_tile_i, tp_tile_j, tp_op_code); end
        n_checks++; if ({jobs_pending, busy} !== {CW'(0), 1'b1}) begin n_fail++; $display("[TB] FAIL single_pop: got pending %0d busy %b want 0 1", jobs_pending, busy); end
        extra = 0;
        for (int n = 0; n < 9; n++) begin
            tick();
            if (tp_start !== 1'b0) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("[TB] FAIL single_pulse_width: got %0d extra start cycles want 0", extra); end
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        exp_completed++;
        n_checks++; if (irq_done !== 1'b1) begin n_fail++; $display("[TB] FAIL single_irq: got %b want 1", irq_done); end
        n_checks++; if (jobs_completed !== 16'(exp_completed)) begin n_fail++; $display("[TB] FAIL single_completed: got %0d want %0d", jobs_completed, exp_completed); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
        n_checks++; if (tp_tile_i !== 3'd1) begin n_fail++; $display("[TB] FAIL single_field_hold: got %0d want 1", tp_tile_i); end
        tick();
        n_checks++; if (irq_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_irq_width: got %b want 0", irq_done); end
    endtask

    task automatic test_back_pressure();
        bit seen;
        for (int k = 0; k < 5; k++) push_job(3'(k), 3'(7 - k), 3'(k + 1));
        n_checks++; if (jobs_pending !== CW'(4)) begin n_fail++; $display("[TB] FAIL bp_pending_full: got %0d want 4", jobs_pending); end
        n_checks++; if (job_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_full: got %b want 0", job_ready); end
        job_valid  = 1'b1;
        job_tile_i = 3'd5;
        job_tile_j = 3'd2;
        job_op     = 3'd6;
        tick();
        job_valid  = 1'b0;
        n_checks++; if (jobs_pending !== CW'(4)) begin n_fail++; $display("[TB] FAIL bp_reject: got %0d want 4", jobs_pending); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if ({tp_tile_i, tp_tile_j, tp_op_code} !== {3'(k), 3'(7 - k), 3'(k + 1)}) begin n_fail++; $display("[TB] FAIL bp_order_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, tp_tile_i, tp_tile_j, tp_op_code, k, 7 - k, k + 1); end
            tp_done = 1'b1;
            tick();
            tp_done = 1'b0;
            exp_completed++;
            n_checks++; if ({irq_done, jobs_completed} !== {1'b1, 16'(exp_completed)}) begin n_fail++; $display("[TB] FAIL bp_done_%0d: got irq %b count %0d want 1 %0d", k, irq_done, jobs_completed, exp_completed); end
            tick();
            if (k < 4) begin
                n_checks++; if (tp_start !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_next_start_%0d: got %b want 1", k, tp_start); end
                tick();
            end else begin
                n_checks++; if ({tp_start, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_drained: got start/busy %b want 00", {tp_start, busy}); end
            end
        end
        push_job(3'd5, 3'd2, 3'd6);
        wait_start(4, seen);
        n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL bp_late_start: got no start want start within 4 cycles"); end
        n_checks++; if ({tp_tile_i, tp_tile_j, tp_op_code} !== {3'd5, 3'd2, 3'd6}) begin n_fail++; $display("[TB] FAIL bp_late_fields: got %0d/%0d/%0d want 5/2/6", tp_tile_i, tp_tile_j, tp_op_code); end
        tick();
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        exp_completed++;
        n_checks++; if (jobs_completed !== 16'(exp_completed)) begin n_fail++; $display("[TB] FAIL bp_late_completed: got %0d want %0d", jobs_completed, exp_completed); end
        tick();
    endtask

    task automatic test_timeout();
        bit early;
        push_job(3'd3, 3'd3, 3'd7);
        push_job(3'd4, 3'd5, 3'd6);
        early = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            tick();
            if (err_timeout !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("[TB] FAIL to_early: got early error want none"); end
        n_checks++; if (jobs_pending !== CW'(1)) begin n_fail++; $display("[TB] FAIL to_queued: got %0d want 1", jobs_pending); end
        tick();
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_err_set: got %b want 1", err_timeout); end
        n_checks++; if ({irq_done, jobs_completed} !== {1'b0, 16'(exp_completed)}) begin n_fail++; $display("[TB] FAIL to_no_complete: got irq %b count %0d want 0 %0d", irq_done, jobs_completed, exp_completed); end
        tick();
        n_checks++; if ({tp_start, tp_tile_i, tp_tile_j, tp_op_code} !== {1'b1, 3'd4, 3'd5, 3'd6}) begin n_fail++; $display("[TB] FAIL to_next_job: got start %b %0d/%0d/%0d want 1 4/5/6", tp_start, tp_tile_i, tp_tile_j, tp_op_code); end
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_err_sticky: got %b want 1", err_timeout); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_err_clear: got %b want 0", err_timeout); end
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        exp_completed++;
        n_checks++; if (jobs_completed !== 16'(exp_completed)) begin n_fail++; $display("[TB] FAIL to_second_done: got %0d want %0d", jobs_completed, exp_completed); end
        tick();
    endtask

    task automatic test_done_at_expiry();
        push_job(3'd6, 3'd1, 3'd2);
        tick();
        for (int n = 0; n < TIMEOUT; n++) tick();
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        exp_completed++;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL expiry_err: got %b want 0", err_timeout); end
        n_checks++; if ({irq_done, jobs_completed} !== {1'b1, 16'(exp_completed)}) begin n_fail++; $display("[TB] FAIL expiry_done: got irq %b count %0d want 1 %0d", irq_done, jobs_completed, exp_completed); end
        tick();
    endtask

    task automatic test_abort();
        int events;
        push_job(3'd1, 3'd1, 3'd1);
        push_job(3'd2, 3'd2, 3'd2);
        push_job(3'd3, 3'd3, 3'd3);
        push_job(3'd4, 3'd4, 3'd4);
        n_checks++; if (jobs_pending !== CW'(3)) begin n_fail++; $display("[TB] FAIL abort_pre_pending: got %0d want 3", jobs_pending); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if ({jobs_pending, job_ready, busy} !== {CW'(0), 1'b1, 1'b1}) begin n_fail++; $display("[TB] FAIL abort_flush: got pending %0d ready %b busy %b want 0 1 1", jobs_pending, job_ready, busy); end
        events = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (tp_start !== 1'b0) events++;
        end
        n_checks++; if (events != 0) begin n_fail++; $display("[TB] FAIL abort_no_start: got %0d starts want 0", events); end
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        n_checks++; if ({irq_done, jobs_completed} !== {1'b0, 16'(exp_completed)}) begin n_fail++; $display("[TB] FAIL abort_drain_done: got irq %b count %0d want 0 %0d", irq_done, jobs_completed, exp_completed); end
        n_checks++; if ({busy, err_timeout} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_idle: got busy/err %b want 00", {busy, err_timeout}); end
        events = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (tp_start !== 1'b0 || irq_done !== 1'b0) events++;
        end
        n_checks++; if (events != 0) begin n_fail++; $display("[TB] FAIL abort_quiet: got %0d events want 0", events); end
        job_valid  = 1'b1;
        job_tile_i = 3'd7;
        job_tile_j = 3'd7;
        job_op     = 3'd7;
        abort      = 1'b1;
        tick();
        job_valid  = 1'b0;
        abort      = 1'b0;
        n_checks++; if (jobs_pending !== CW'(0)) begin n_fail++; $display("[TB] FAIL abort_push_discard: got %0d want 0", jobs_pending); end
        tick();
        n_checks++; if ({tp_start, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_idle_no_start: got start/busy %b want 00", {tp_start, busy}); end
    endtask

    task automatic test_async_reset();
        push_job(3'd5, 3'd6, 3'd7);
        tick();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_busy_before: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_completed = 0;
        n_checks++; if ({busy, tp_start, irq_done, err_timeout, job_ready} !== 5'b00001) begin n_fail++; $display("[TB] FAIL ar_flags: got %b want 00001", {busy, tp_start, irq_done, err_timeout, job_ready}); end
        n_checks++; if ({tp_tile_i, tp_tile_j, tp_op_code} !== 9'd0) begin n_fail++; $display("[TB] FAIL ar_fields: got %h want 0", {tp_tile_i, tp_tile_j, tp_op_code}); end
        n_checks++; if ({jobs_pending, jobs_completed} !== {CW'(0), 16'd0}) begin n_fail++; $display("[TB] FAIL ar_counts: got pending %0d completed %0d want 0 0", jobs_pending, jobs_completed); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        push_job(3'd2, 3'd3, 3'd4);
        tick();
        n_checks++; if ({tp_start, tp_tile_i, tp_tile_j, tp_op_code} !== {1'b1, 3'd2, 3'd3, 3'd4}) begin n_fail++; $display("[TB] FAIL ar_restart: got start %b %0d/%0d/%0d want 1 2/3/4", tp_start, tp_tile_i, tp_tile_j, tp_op_code); end
        tick();
        tp_done = 1'b1;
        tick();
        tp_done = 1'b0;
        exp_completed++;
        n_checks++; if (jobs_completed !== 16'(exp_completed)) begin n_fail++; $display("[TB] FAIL ar_completed: got %0d want %0d", jobs_completed, exp_completed); end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test want end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        job_valid  = 1'b0;
        job_tile_i = 3'd0;
        job_tile_j = 3'd0;
        job_op     = 3'd0;
        abort      = 1'b0;
        tp_done    = 1'b0;
        err_clear  = 1'b0;
        test_reset();
        test_single_job();
        test_back_pressure();
        test_timeout();
        test_done_at_expiry();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
